// File: rtl/ifmap_scan_ctrl_pkg.sv
// Shared configuration for the IFMAP raster-scan sequencer: geometry, derived sizes, state encoding.
package ifmap_scan_ctrl_pkg;

  localparam int IFMAP_H  = 5;
  localparam int IFMAP_W  = 5;
  localparam int IFMAP_C  = 1;
  localparam int FILTER_W = 3;
  localparam int ADDR_W   = 5;

  localparam int IF_SIZE   = IFMAP_H * IFMAP_W;
  localparam int LAST_ADDR = IF_SIZE * IFMAP_C - 1;

  // A dimension of 1 still needs a 1-bit counter so the cascade stays uniform.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W = cnt_w(IFMAP_W);
  localparam int ROW_W = cnt_w(IFMAP_H);
  localparam int CH_W  = cnt_w(IFMAP_C);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ifmap_scan_ctrl_if.sv
// Control/pixel bus of the IFMAP scan sequencer; win_cnt_o exists only with IFMAP_SCAN_WINCNT_EN.
interface ifmap_scan_ctrl_if;
  import ifmap_scan_ctrl_pkg::*;

  logic              start_i;
  logic              ready_i;
  logic [ADDR_W-1:0] image_ram_addr_o;
  logic              rd_en_o;
  logic              pix_valid_o;
  logic [ADDR_W-1:0] pix_addr_o;
  logic              win_valid_o;
  logic              last_pix_o;
  logic              busy_o;
  logic              done_o;
`ifdef IFMAP_SCAN_WINCNT_EN
  logic [ADDR_W-1:0] win_cnt_o;
`endif

  modport slave (
    input  start_i, ready_i,
    output image_ram_addr_o, rd_en_o, pix_valid_o, pix_addr_o,
           win_valid_o, last_pix_o, busy_o, done_o
`ifdef IFMAP_SCAN_WINCNT_EN
    , output win_cnt_o
`endif
  );

  modport master (
    output start_i, ready_i,
    input  image_ram_addr_o, rd_en_o, pix_valid_o, pix_addr_o,
           win_valid_o, last_pix_o, busy_o, done_o
`ifdef IFMAP_SCAN_WINCNT_EN
    , input win_cnt_o
`endif
  );

endinterface

// File: rtl/ifmap_coord_cnt.sv
// Cascaded col -> row -> ch counters for the raster scan; advances once per accepted read.
module ifmap_coord_cnt
  import ifmap_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             col_wrap, row_wrap, ch_wrap;

  assign col_wrap = (col_q == COL_W'(IFMAP_W - 1));
  assign row_wrap = (row_q == ROW_W'(IFMAP_H - 1));
  assign ch_wrap  = (ch_q  == CH_W'(IFMAP_C - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
      ch_d  = '0;
    end else if (adv_i) begin
      col_d = col_wrap ? '0 : col_q + 1'b1;
      if (col_wrap) begin
        row_d = row_wrap ? '0 : row_q + 1'b1;
        if (row_wrap) ch_d = ch_wrap ? '0 : ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ch_q  <= ch_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_wrap & row_wrap & ch_wrap;

endmodule

// File: rtl/ifmap_scan_ctrl.sv
// IFMAP raster-scan sequencer: issues image RAM reads, tracks 1-cycle read latency, flags window closes.
// Optional window counter output enabled by defining IFMAP_SCAN_WINCNT_EN.
module ifmap_scan_ctrl
  import ifmap_scan_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ifmap_scan_ctrl_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
  localparam logic [COL_W-1:0]  COL_MIN = COL_W'(FILTER_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MIN = ROW_W'(FILTER_W - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic              pix_vld_q, win_vld_q, last_q, busy_q, done_q;

  logic              rd_en, start_ok, cnt_last;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  assign rd_en    = (state_q == ST_SCAN) & bus.ready_i;
  assign start_ok = (state_q == ST_IDLE) & bus.start_i;

  ifmap_coord_cnt u_coord (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_ok),
    .adv_i  (rd_en),
    .col_o  (col),
    .row_o  (row),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      pix_addr_q <= '0;
      pix_vld_q  <= 1'b0;
      win_vld_q  <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Read-return stage: everything issued this cycle appears one cycle later.
      pix_vld_q  <= rd_en;
      pix_addr_q <= addr_q;
      win_vld_q  <= rd_en & (row >= ROW_MIN) & (col >= COL_MIN);
      last_q     <= rd_en & cnt_last;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_q <= ST_SCAN;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (rd_en) begin
            if (addr_q == LAST_A) state_q <= ST_DRAIN;
            else                  addr_q  <= addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef IFMAP_SCAN_WINCNT_EN
  logic [ADDR_W-1:0] win_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) win_cnt_q <= '0;
    else if (win_vld_q)  win_cnt_q <= win_cnt_q + 1'b1;
  end

  assign bus.win_cnt_o = win_cnt_q;
`endif

  assign bus.image_ram_addr_o = addr_q;
  assign bus.rd_en_o          = rd_en;
  assign bus.pix_valid_o      = pix_vld_q;
  assign bus.pix_addr_o       = pix_addr_q;
  assign bus.win_valid_o      = win_vld_q;
  assign bus.last_pix_o       = last_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;

endmodule

// File: tb/tb_ifmap_scan_ctrl.sv
// Self-checking bench for ifmap_scan_ctrl: per-cycle vector tables plus a pixel scoreboard.
module tb_ifmap_scan_ctrl;
  import ifmap_scan_ctrl_pkg::*;

  logic clk;
  logic rst;

  ifmap_scan_ctrl_if bus();

  ifmap_scan_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              win;
    logic              last;
  } pix_t;

  typedef struct {
    logic              start;
    logic              ready;
    logic              chk_addr;
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic              pv;
    logic              busy;
    logic              done;
  } vec_t;

  pix_t sbq[$];
  vec_t tbl[64];
  int   tbl_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_win = 0;
  int   n_done = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected pixel stream of one full scan, derived from address arithmetic.
  task automatic push_scan();
    for (int a = 0; a <= LAST_ADDR; a++) begin
      pix_t p;
      int   r;
      int   c;
      r      = (a % IF_SIZE) / IFMAP_W;
      c      = a % IFMAP_W;
      p.addr = ADDR_W'(a);
      p.win  = (r >= FILTER_W - 1) && (c >= FILTER_W - 1);
      p.last = (a == LAST_ADDR);
      sbq.push_back(p);
    end
  endtask

  // Builds the per-cycle vector table for a scan started in cycle 0.
  task automatic fill(input int hold_addr, input int hold_len, input int restart_addr);
    int   a;
    int   held;
    int   k;
    logic r;
    logic prev_rd;
    a = 0; held = 0; k = 1; prev_rd = 1'b0;
    forever begin
      r = !(a == hold_addr && held < hold_len);
      if (!r) held++;
      tbl[k].start    = (a == restart_addr);
      tbl[k].ready    = r;
      tbl[k].chk_addr = 1'b1;
      tbl[k].addr     = ADDR_W'(a);
      tbl[k].rd_en    = r;
      tbl[k].pv       = prev_rd;
      tbl[k].busy     = 1'b1;
      tbl[k].done     = 1'b0;
      prev_rd = r;
      k++;
      if (r && a == LAST_ADDR) break;
      if (r) a++;
    end
    tbl[k] = '{start: 1'b0, ready: 1'b1, chk_addr: 1'b0, addr: '0,
               rd_en: 1'b0, pv: 1'b1, busy: 1'b1, done: 1'b0};
    k++;
    tbl[k] = '{start: 1'b0, ready: 1'b1, chk_addr: 1'b0, addr: '0,
               rd_en: 1'b0, pv: 1'b0, busy: 1'b0, done: 1'b1};
    tbl_n = k + 1;
  endtask

  task automatic run_table(input string tag);
    int d0;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.ready_i = 1'b1;
    push_scan();
    n_win = 0;
    d0 = n_done;
    for (int k = 1; k < tbl_n; k++) begin
      @(posedge clk); #1;
      bus.start_i = tbl[k].start;
      bus.ready_i = tbl[k].ready;
      #1;
      if (tbl[k].chk_addr)
        chk($sformatf("%s_c%0d_addr", tag, k), bus.image_ram_addr_o, tbl[k].addr);
      chk($sformatf("%s_c%0d_rd_en", tag, k), bus.rd_en_o, tbl[k].rd_en);
      chk($sformatf("%s_c%0d_pix_valid", tag, k), bus.pix_valid_o, tbl[k].pv);
      chk($sformatf("%s_c%0d_busy", tag, k), bus.busy_o, tbl[k].busy);
      chk($sformatf("%s_c%0d_done", tag, k), bus.done_o, tbl[k].done);
`ifdef IFMAP_SCAN_WINCNT_EN
      if (k == 1) chk($sformatf("%s_wincnt_clear", tag), bus.win_cnt_o, 0);
`endif
    end
    @(negedge clk); #1;
    chk($sformatf("%s_win_count", tag), n_win, 9);
    chk($sformatf("%s_done_pulses", tag), n_done - d0, 1);
    chk($sformatf("%s_sb_left", tag), sbq.size(), 0);
`ifdef IFMAP_SCAN_WINCNT_EN
    chk($sformatf("%s_wincnt_final", tag), bus.win_cnt_o, 9);
`endif
    bus.start_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},      bus.image_ram_addr_o, 0);
    chk({tag, "_rd_en"},     bus.rd_en_o, 0);
    chk({tag, "_pix_valid"}, bus.pix_valid_o, 0);
    chk({tag, "_pix_addr"},  bus.pix_addr_o, 0);
    chk({tag, "_win_valid"}, bus.win_valid_o, 0);
    chk({tag, "_last_pix"},  bus.last_pix_o, 0);
    chk({tag, "_busy"},      bus.busy_o, 0);
    chk({tag, "_done"},      bus.done_o, 0);
`ifdef IFMAP_SCAN_WINCNT_EN
    chk({tag, "_win_cnt"},   bus.win_cnt_o, 0);
`endif
  endtask

  // Pixel monitor: every returning pixel is matched against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done_o) n_done++;
      if (bus.pix_valid_o) begin
        if (sbq.size() == 0) begin
          chk("pix_unexpected", 1, 0);
        end else begin
          pix_t e;
          e = sbq.pop_front();
          chk("pix_addr", bus.pix_addr_o, e.addr);
          chk($sformatf("win_valid_a%0d", e.addr), bus.win_valid_o, e.win);
          chk($sformatf("last_pix_a%0d", e.addr), bus.last_pix_o, e.last);
          if (bus.win_valid_o) n_win++;
        end
      end else begin
        chk("stray_win_valid", bus.win_valid_o, 0);
        chk("stray_last_pix", bus.last_pix_o, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   d0;
    logic found;
    bus.start_i = 1'b0;
    bus.ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_rd_en", bus.rd_en_o, 0);
    mon_en = 1'b1;

    fill(-1, 0, -1);
    run_table("full");
    fill(-1, 0, -1);
    run_table("b2b");
    fill(7, 3, -1);
    run_table("stall");
    fill(-1, 0, 10);
    run_table("restart");

    // Abort mid-scan with reset, then scan again from address 0.
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.ready_i = 1'b1;
    push_scan();
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.image_ram_addr_o == 15) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_addr15", found, 1);
    d0 = n_done;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_all_zero("abort");
    chk("abort_sb_left", sbq.size(), LAST_ADDR - 14);
    sbq.delete();
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_idle_busy", bus.busy_o, 0);

    fill(-1, 0, -1);
    run_table("rescan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
